// File: rtl/id_stage.sv
// RV64I decode stage: field split, immediate generation and a 3-read/1-write integer register file.
// Optional write-through register file when ID_WB_BYPASS_EN is defined.
module id_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            flush,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      wrd,
  input  logic [6:0]      wopcode,
  input  logic [4:0]      rs1_addr_control,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] rs1_data_control
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_RW   = 7'b0111011;
  localparam logic [6:0] OP_IW   = 7'b0011011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [XLEN-1:0] rf_q [NREG];
  logic            wop_ok;
  logic            we;
  logic            kill;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rd1, rd2, rdc;

  // Only instructions that produce a register result may write back.
  always_comb begin
    wop_ok = 1'b0;
    case (wopcode)
      OP_R, OP_I, OP_LD, OP_LUI, OP_AUIP, OP_JAL, OP_JALR, OP_RW, OP_IW: wop_ok = 1'b1;
      default: wop_ok = 1'b0;
    endcase
  end

  assign we = !rst && wop_ok && (wrd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we) begin
      rf_q[wrd] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = (a == 5'd0) ? '0 : rf_q[a];
`ifdef ID_WB_BYPASS_EN
    if (we && (a == wrd)) v = wdata;
`endif
    return v;
  endfunction

  assign rd1 = rf_read(inst[19:15]);
  assign rd2 = rf_read(inst[24:20]);
  assign rdc = rf_read(rs1_addr_control);

  always_comb begin
    imm_d = '0;
    case (inst[6:0])
      OP_LD, OP_I, OP_IW, OP_JALR:
        imm_d = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OP_ST:
        imm_d = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      OP_BR:
        imm_d = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIP:
        imm_d = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      OP_JAL:
        imm_d = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  // A flushed instruction becomes a bubble; the control-unit port stays live through flush.
  assign kill = rst || flush;

  assign opcode           = kill ? 7'd0 : inst[6:0];
  assign rd               = kill ? 5'd0 : inst[11:7];
  assign func3            = kill ? 3'd0 : inst[14:12];
  assign func7            = kill ? 7'd0 : inst[31:25];
  assign imm_ext          = kill ? '0   : imm_d;
  assign data1            = kill ? '0   : rd1;
  assign data2            = kill ? '0   : rd2;
  assign rs1_data_control = rst  ? '0   : rdc;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations follow ID_WB_BYPASS_EN when defined.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        flush;
  logic [63:0] wdata;
  logic [4:0]  wrd;
  logic [6:0]  wopcode;
  logic [4:0]  rs1_addr_control;
  logic [6:0]  opcode;
  logic [63:0] data1, data2, imm_ext, rs1_data_control;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [6:0]  func7;

  int pass_cnt = 0;
  int tot_cnt  = 0;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  id_stage #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .flush(flush), .wdata(wdata), .wrd(wrd),
    .wopcode(wopcode), .rs1_addr_control(rs1_addr_control), .opcode(opcode),
    .data1(data1), .data2(data2), .rd(rd), .func3(func3), .func7(func7),
    .imm_ext(imm_ext), .rs1_data_control(rs1_data_control)
  );

  always #5 clk = ~clk;

  task automatic idle_wb();
    wrd = 5'd0; wopcode = 7'd0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; inst = 32'h002082B3; rs1_addr_control = 5'd1;
    wrd = 5'd6; wopcode = 7'b0110011; wdata = 64'hDEAD;
    @(negedge clk); #1;
    tot_cnt++; if (opcode !== 7'd0 || rd !== 5'd0 || func7 !== 7'd0 || func3 !== 3'd0)
      $display("FAIL rst_fields got op=%h rd=%h f3=%h f7=%h exp 0", opcode, rd, func3, func7); else pass_cnt++;
    tot_cnt++; if (rs1_data_control !== 64'd0 || data1 !== 64'd0 || imm_ext !== 64'd0)
      $display("FAIL rst_data got ctl=%h d1=%h imm=%h exp 0", rs1_data_control, data1, imm_ext); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; idle_wb(); rs1_addr_control = 5'd6;
    #1;
    tot_cnt++; if (rs1_data_control !== 64'd0)
      $display("FAIL rst_beats_write got %h exp 0", rs1_data_control); else pass_cnt++;
  endtask

  task automatic test_decode();
    @(negedge clk);
    inst = 32'h002082B3; #1;
    tot_cnt++; if (opcode !== 7'b0110011 || rd !== 5'd5 || func3 !== 3'd0 || func7 !== 7'd0)
      $display("FAIL add_fields got op=%h rd=%h f3=%h f7=%h exp 33/5/0/0", opcode, rd, func3, func7); else pass_cnt++;
    tot_cnt++; if (imm_ext !== 64'd0 || data1 !== 64'd0 || data2 !== 64'd0)
      $display("FAIL add_data got imm=%h d1=%h d2=%h exp 0", imm_ext, data1, data2); else pass_cnt++;
    inst = 32'h00A08293; #1;
    tot_cnt++; if (imm_ext !== 64'd10 || opcode !== 7'b0010011)
      $display("FAIL addi_imm got %h exp 10", imm_ext); else pass_cnt++;
    inst = 32'hFFF08293; #1;
    tot_cnt++; if (imm_ext !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL addi_neg got %h exp ffffffffffffffff", imm_ext); else pass_cnt++;
    inst = 32'h0050A023; #1;
    tot_cnt++; if (opcode !== 7'b0100011 || func3 !== 3'b010 || imm_ext !== 64'd0)
      $display("FAIL sw got op=%h f3=%h imm=%h exp 23/2/0", opcode, func3, imm_ext); else pass_cnt++;
  endtask

  task automatic test_imm();
    @(negedge clk);
    inst = 32'h000202B7; #1;
    tot_cnt++; if (imm_ext !== 64'h20000)
      $display("FAIL lui got %h exp 20000", imm_ext); else pass_cnt++;
    inst = 32'hFE2088E3; #1;
    tot_cnt++; if (imm_ext !== -64'sd16)
      $display("FAIL beq got %h exp fffffffffffffff0", imm_ext); else pass_cnt++;
    inst = 32'hFEDFF0EF; #1;
    tot_cnt++; if (imm_ext !== -64'sd20)
      $display("FAIL jal got %h exp ffffffffffffffec", imm_ext); else pass_cnt++;
  endtask

  task automatic test_write();
    @(negedge clk);
    inst = 32'h002082B3; rs1_addr_control = 5'd1;
    wrd = 5'd1; wdata = 64'd5; wopcode = 7'b0000011; #1;
    tot_cnt++; if (rs1_data_control !== (BYP ? 64'd5 : 64'd0))
      $display("FAIL same_cycle_read got %h exp %h", rs1_data_control, BYP ? 64'd5 : 64'd0); else pass_cnt++;
    @(posedge clk); #1; idle_wb(); #1;
    tot_cnt++; if (rs1_data_control !== 64'd5)
      $display("FAIL ctl_read got %h exp 5", rs1_data_control); else pass_cnt++;
    tot_cnt++; if (data1 !== 64'd5)
      $display("FAIL data1_read got %h exp 5", data1); else pass_cnt++;
  endtask

  task automatic test_x0_and_nowrite();
    @(negedge clk);
    wrd = 5'd0; wopcode = 7'b1101111; wdata = 64'h55; rs1_addr_control = 5'd0;
    @(posedge clk); #1; idle_wb(); #1;
    tot_cnt++; if (rs1_data_control !== 64'd0)
      $display("FAIL x0_write got %h exp 0", rs1_data_control); else pass_cnt++;
    @(negedge clk);
    wrd = 5'd3; wopcode = 7'b0100011; wdata = 64'h77; rs1_addr_control = 5'd3; #1;
    tot_cnt++; if (rs1_data_control !== 64'd0)
      $display("FAIL store_no_bypass got %h exp 0", rs1_data_control); else pass_cnt++;
    @(posedge clk); #1; idle_wb(); #1;
    tot_cnt++; if (rs1_data_control !== 64'd0)
      $display("FAIL store_no_write got %h exp 0", rs1_data_control); else pass_cnt++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; inst = 32'h00A08293; rs1_addr_control = 5'd1;
    wrd = 5'd4; wopcode = 7'b0111011; wdata = 64'h9; #1;
    tot_cnt++; if (opcode !== 7'd0 || imm_ext !== 64'd0 || rd !== 5'd0 || data1 !== 64'd0)
      $display("FAIL flush_bubble got op=%h imm=%h rd=%h d1=%h exp 0", opcode, imm_ext, rd, data1); else pass_cnt++;
    tot_cnt++; if (rs1_data_control !== 64'd5)
      $display("FAIL flush_ctl got %h exp 5", rs1_data_control); else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; idle_wb(); rs1_addr_control = 5'd4; #1;
    tot_cnt++; if (rs1_data_control !== 64'd9)
      $display("FAIL flush_write got %h exp 9", rs1_data_control); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    inst = 32'h002082B3; wrd = 5'd2; wdata = 64'd7; wopcode = 7'b0110011; #1;
    tot_cnt++; if (data2 !== (BYP ? 64'd7 : 64'd0))
      $display("FAIL bypass_data2 got %h exp %h", data2, BYP ? 64'd7 : 64'd0); else pass_cnt++;
    @(posedge clk); #1;
    wrd = 5'd2; wdata = 64'd8; wopcode = 7'b0011011; #1;
    tot_cnt++; if (data2 !== (BYP ? 64'd8 : 64'd7))
      $display("FAIL b2b_data2 got %h exp %h", data2, BYP ? 64'd8 : 64'd7); else pass_cnt++;
    @(posedge clk); #1; idle_wb(); #1;
    tot_cnt++; if (data2 !== 64'd8 || data1 !== 64'd5)
      $display("FAIL b2b_final got d1=%h d2=%h exp 5/8", data1, data2); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rs1_addr_control = 5'd1; #1;
    tot_cnt++; if (rs1_data_control !== 64'd0 || data2 !== 64'd0)
      $display("FAIL rst_clears got ctl=%h d2=%h exp 0", rs1_data_control, data2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_imm();
    test_write();
    test_x0_and_nowrite();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
